// File: rtl/key_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_cond_pkg
// Brief    : Shared state type, parameter defaults and helpers for the key
//            pulse conditioner family.
// Revision : 1.0 - initial release
// ============================================================================
package key_cond_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEATING  = 3'd3,
        DB_RELEASE = 3'd4
    } kc_state_t;

    localparam int KC_DEBOUNCE_DEF = 250000;
    localparam int KC_DELAY_DEF    = 25000000;
    localparam int KC_PERIOD_DEF   = 5000000;

    localparam int KC_DEBOUNCE_SIM = 4;
    localparam int KC_DELAY_SIM    = 20;
    localparam int KC_PERIOD_SIM   = 8;

    function automatic int kc_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sync.sv
`default_nettype none
// ============================================================================
// Module   : key_sync
// Brief    : Two-flop synchronizer for an active-low switch; output 1 = active.
// Revision : 1.0 - initial release
// ============================================================================
module key_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_n_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Both stages reset to "released" so a held key looks like a fresh press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= ~async_n_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse_conditioner
// Brief    : Synchronize, debounce and auto-repeat one DE1 push-button into
//            single-cycle FIFO command strobes.
// Revision : 1.0 - initial release
// ============================================================================
module key_pulse_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_DEF,
    parameter int REPEAT_DELAY    = KC_DELAY_DEF,
    parameter int REPEAT_PERIOD   = KC_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic pulse,
    output logic repeat_active
);

    localparam int CNT_W = $clog2(kc_max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    // Debounce waits one count longer than the repeat timers so that press
    // and release both land DEBOUNCE_CYCLES+3 edges after the raw change.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic            s;
    kc_state_t       state_q,   state_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic            pulse_q,   pulse_d;
    logic            pressed_q, pressed_d;
    logic            repeat_q,  repeat_d;

    key_sync u_sync (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .async_n_i (key_n),
        .sync_o    (s)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pulse_q   <= 1'b0;
            pressed_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            pressed_q <= pressed_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pulse_d   = 1'b0;
        pressed_d = pressed_q;
        repeat_d  = repeat_q;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (s) begin
                    state_d = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q == DEB_LAST) begin
                    state_d   = HELD;
                    count_d   = '0;
                    pulse_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            HELD: begin
                if (!s) begin
                    state_d = DB_RELEASE;
                    count_d = '0;
                end else if (REPEAT_EN) begin
                    if (count_q == DELAY_LAST) begin
                        state_d  = REPEATING;
                        count_d  = '0;
                        pulse_d  = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end

            REPEATING: begin
                if (!s) begin
                    state_d  = DB_RELEASE;
                    count_d  = '0;
                    repeat_d = 1'b0;
                end else if (count_q == PERIOD_LAST) begin
                    count_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            DB_RELEASE: begin
                // A return to pressed here is a glitch: back to HELD, delay restarts.
                if (s) begin
                    state_d = HELD;
                    count_d = '0;
                end else if (count_q == DEB_LAST) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    pressed_d = 1'b0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = IDLE;
                count_d   = '0;
                pressed_d = 1'b0;
                repeat_d  = 1'b0;
            end
        endcase
    end

    assign pressed       = pressed_q;
    assign pulse         = pulse_q;
    assign repeat_active = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_pulse_conditioner
// Brief    : Self-checking bench: rule-level model compared every cycle plus
//            literal event timings for the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_pulse_conditioner;
    import key_cond_pkg::*;

    localparam int DEB = KC_DEBOUNCE_SIM;
    localparam int DLY = KC_DELAY_SIM;
    localparam int PER = KC_PERIOD_SIM;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic key_n    = 1'b1;
    logic pressed, pulse, repeat_active;

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER),
        .REPEAT_EN       (1'b1)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .key_n         (key_n),
        .pressed       (pressed),
        .pulse         (pulse),
        .repeat_active (repeat_active)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Inputs as seen by the active edge, read back on the falling edge.
    logic smp_rst = 1'b1;
    logic smp_key = 1'b1;
    always @(posedge CLOCK_50) begin
        smp_rst <= reset;
        smp_key <= key_n;
    end

    // Rule-level model: the press/release is accepted once the synchronized
    // level has been seen DEB+2 edges in a row; repeats fire at hold times
    // DLY, DLY+PER, ... counted from the last (re)entry into a steady hold.
    logic mk1, mk2, run_val, m_pressed, m_pulse, m_rep, m_hold;
    int   run_len, hold_t;

    task automatic model_step(input logic rst_s, input logic key_s);
        logic s;
        if (rst_s) begin
            mk1 = 1'b1; mk2 = 1'b1; run_val = 1'b0; run_len = 0;
            m_pressed = 1'b0; m_pulse = 1'b0; m_rep = 1'b0; m_hold = 1'b0; hold_t = 0;
        end else begin
            s   = ~mk2;
            mk2 = mk1;
            mk1 = key_s;
            if (s == run_val) run_len++;
            else begin run_val = s; run_len = 1; end
            m_pulse = 1'b0;
            if (!m_pressed) begin
                if (s && run_len == DEB + 2) begin
                    m_pressed = 1'b1; m_pulse = 1'b1; m_hold = 1'b1; hold_t = 0;
                end
            end else if (!s) begin
                m_hold = 1'b0;
                m_rep  = 1'b0;
                if (run_len == DEB + 2) m_pressed = 1'b0;
            end else if (!m_hold) begin
                m_hold = 1'b1;
                hold_t = 0;
            end else begin
                hold_t++;
                if (hold_t >= DLY && (hold_t - DLY) % PER == 0) begin
                    m_pulse = 1'b1;
                    m_rep   = 1'b1;
                end
            end
        end
    endtask

    // Event log, edge numbers are absolute (first active edge = 0).
    int edge_no = -1;
    int pulse_edges[$];
    int p_rise, p_fall, r_rise, r_fall;
    logic prev_p = 1'b0, prev_r = 1'b0;

    function automatic void clear_events();
        pulse_edges.delete();
        p_rise = -1; p_fall = -1; r_rise = -1; r_fall = -1;
    endfunction

    initial begin
        clear_events();
        forever begin
            @(negedge CLOCK_50);
            edge_no++;
            model_step(smp_rst, smp_key);
            chk("pulse",         {31'd0, pulse},         {31'd0, m_pulse});
            chk("pressed",       {31'd0, pressed},       {31'd0, m_pressed});
            chk("repeat_active", {31'd0, repeat_active}, {31'd0, m_rep});
            if (pulse === 1'b1) pulse_edges.push_back(edge_no);
            if (pressed === 1'b1 && !prev_p && p_rise < 0) p_rise = edge_no;
            if (pressed === 1'b0 &&  prev_p && p_fall < 0) p_fall = edge_no;
            if (repeat_active === 1'b1 && !prev_r && r_rise < 0) r_rise = edge_no;
            if (repeat_active === 1'b0 &&  prev_r && r_fall < 0) r_fall = edge_no;
            prev_p = (pressed === 1'b1);
            prev_r = (repeat_active === 1'b1);
        end
    end

    // Drive key_n for n active edges; called just after a falling edge.
    task automatic drive(input logic k, input int n);
        key_n = k;
        repeat (n) begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    int exp_q[$];

    task automatic check_pulses(input string tag, input int base);
        chk({tag, " pulse count"}, pulse_edges.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pulse_edges.size(); i++)
            chk($sformatf("%s pulse[%0d] edge", tag, i), pulse_edges[i] - base, exp_q[i]);
    endtask

    int base;

    initial begin
        @(negedge CLOCK_50);
        #1;
        // 1: reset with key released
        reset = 1'b1;
        drive(1'b1, 3);
        reset = 1'b0;
        chk("s1 pressed", {31'd0, pressed}, 32'd0);
        chk("s1 pulse", {31'd0, pulse}, 32'd0);
        chk("s1 repeat_active", {31'd0, repeat_active}, 32'd0);
        drive(1'b1, 4);

        // 2: single clean press
        clear_events();
        base = edge_no + 1;
        drive(1'b0, 10);
        drive(1'b1, 12);
        exp_q = '{7};
        check_pulses("s2", base);
        chk("s2 pressed rise", p_rise - base, 7);
        chk("s2 pressed fall", p_fall - base, 17);

        // 3: bounce then stable press
        clear_events();
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 2);
        drive(1'b1, 1);
        base = edge_no + 1;
        drive(1'b0, 12);
        drive(1'b1, 12);
        exp_q = '{7};
        check_pulses("s3", base);
        chk("s3 pressed rise", p_rise - base, 7);

        // 4: long hold with auto-repeat
        clear_events();
        base = edge_no + 1;
        drive(1'b0, 60);
        drive(1'b1, 12);
        exp_q = '{7, 27, 35, 43, 51, 59};
        check_pulses("s4", base);
        chk("s4 repeat rise", r_rise - base, 27);
        chk("s4 repeat fall", r_fall - base, 62);
        chk("s4 pressed fall", p_fall - base, 67);

        // 5: one-cycle release glitch while held
        clear_events();
        base = edge_no + 1;
        drive(1'b0, 15);
        drive(1'b1, 1);
        drive(1'b0, 34);
        drive(1'b1, 12);
        exp_q = '{7, 38, 46};
        check_pulses("s5", base);
        chk("s5 pressed fall", p_fall - base, 57);
        chk("s5 repeat rise", r_rise - base, 38);

        // 6: reset during auto-repeat with key still held
        clear_events();
        base = edge_no + 1;
        drive(1'b0, 30);
        reset = 1'b1;
        drive(1'b0, 2);
        reset = 1'b0;
        drive(1'b0, 30);
        drive(1'b1, 12);
        exp_q = '{7, 27, 39, 59};
        check_pulses("s6", base);
        chk("s6 pressed fall on reset", p_fall - base, 30);
        chk("s6 repeat fall on reset", r_fall - base, 30);

        drive(1'b1, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_pulse_conditioner.md
Name: key_pulse_conditioner

Overview:
Conditions one raw active-low DE1 push-button into a clean one-cycle command pulse for the FIFO read and write ports. It sits directly upstream of the FIFO; the top level uses two instances, one for KEY[3] (read) and one for KEY[2] (write). The block replaces the bare edge-shortener with three functions:
- a 2-FF synchronizer;
- a debounce filter;
- hold-to-auto-repeat, which allows burst fills and drains.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a press or a release (5 ms at 50 MHz); minimum 2.
REPEAT_DELAY, 25000000, cycles in HELD before the first auto-repeat pulse (0.5 s); minimum 2.
REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses (0.1 s); minimum 2.
REPEAT_EN, 1, 1 enables auto-repeat; 0 gives a single pulse per press.

Ports:
CLOCK_50  input  1  system clock
reset  input  1  synchronous, active-high reset
key_n  input  1  raw asynchronous button, 0 = pressed
pressed  output  1  debounced level, 1 = button accepted as held
pulse  output  1  one-cycle command strobe to FIFO read/write
repeat_active  output  1  high while auto-repeating

Behaviour:
- Clocking and reset:
  - Clock is CLOCK_50. reset is synchronous and active-high.
  - On reset: synchronizer flops load "released"; state = IDLE; counter = 0; pressed = 0, pulse = 0, repeat_active = 0.
  - All outputs are registered.
- Synchronizer: s = inverted 2-FF sync of key_n, so s = 1 means pressed.
- Counter: one shared counter, width $clog2 of the largest parameter, plus 1. It clears on every state change.
- FSM states: IDLE, DB_PRESS, HELD, REPEATING, DB_RELEASE.
- IDLE:
  - s = 1 -> DB_PRESS.
- DB_PRESS (counts while s = 1):
  - s = 0 -> IDLE, with no pulse.
  - s stable 1 for DEBOUNCE_CYCLES -> HELD; pulse = 1 for one cycle; pressed = 1.
- HELD:
  - s = 0 -> DB_RELEASE.
  - REPEAT_EN = 1 and count reaches REPEAT_DELAY -> REPEATING; one pulse; repeat_active = 1.
  - REPEAT_EN = 0 -> remains in HELD until release.
- REPEATING:
  - One pulse every REPEAT_PERIOD cycles.
  - s = 0 -> DB_RELEASE; repeat_active = 0.
- DB_RELEASE (pressed stays 1):
  - s = 1 before DEBOUNCE_CYCLES elapse -> HELD with the counter cleared. This is a glitch: no pulse, and the repeat delay restarts.
  - s stable 0 for DEBOUNCE_CYCLES -> IDLE; pressed = 0.
- Latency:
  - Cycle 0 is the first edge at which key_n is sampled 0.
  - The first pulse and the rise of pressed are visible after edge DEBOUNCE_CYCLES+3.
  - Release is symmetric: pressed falls DEBOUNCE_CYCLES+3 edges after key_n is first sampled 1.
- Pulse width: never more than one cycle. Consecutive pulses are at least 2 cycles apart, because REPEAT_PERIOD >= 2.
- Reset mid-operation: takes priority over everything. If the key is still held after reset deasserts, it is treated as a fresh press and produces exactly one debounced pulse.
- Any key_n activity shorter than DEBOUNCE_CYCLES produces no pulse and no change on pressed.

Decomposition:
- Package key_cond_pkg holds:
  - typedef enum logic [2:0] kc_state_t {IDLE, DB_PRESS, HELD, REPEATING, DB_RELEASE};
  - default constants KC_DEBOUNCE_DEF, KC_DELAY_DEF and KC_PERIOD_DEF;
  - simulation constants KC_DEBOUNCE_SIM = 4, KC_DELAY_SIM = 20, KC_PERIOD_SIM = 8.
- Sub-module key_sync: a 2-FF synchronizer with inversion and synchronous reset to "released". It is reused for SW inputs later.

Test Plan:
All scenarios use the SIM parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, REPEAT_EN = 1.
1. Reset held 3 cycles with key_n = 1 -> pressed = pulse = repeat_active = 0 throughout; state IDLE.
2. key_n low for 10 cycles, then high -> exactly one pulse, after edge 7; pressed = 1 from edge 7; pressed = 0 seven edges after key_n returns high.
3. Bounce pattern low 2, high 1, low 2, high 1 cycles, then stable low -> no pulse during the bounce; one pulse 7 edges after the final stable low begins.
4. key_n low for 60 cycles -> pulses after edges 7, 27, 35, 43, 51 and 59 only; repeat_active = 1 from edge 27 until release is sampled.
5. While HELD (edge 15), a 1-cycle high glitch on key_n -> no extra pulse; pressed stays 1; first repeat pulse moves to 20 cycles after the glitch clears.
6. Reset asserted for 2 cycles during REPEATING with key_n still low -> all outputs 0 the cycle after reset is sampled; after deassertion, one pulse at +7 edges, then repeats resume after a further 20 cycles.
